// File: rtl/picorv32_pcpi_hub_if.sv
// PCPI bundle between the core, the hub and the coprocessors.
// slave: the hub's view. master: the side that drives the core and cp inputs.
interface picorv32_pcpi_hub_if #(
  parameter int NUM_CP = 2
);
  logic                  core_pcpi_valid;
  logic [31:0]           core_pcpi_insn;
  logic [31:0]           core_pcpi_rs1;
  logic [31:0]           core_pcpi_rs2;
  logic                  core_pcpi_wr;
  logic [31:0]           core_pcpi_rd;
  logic                  core_pcpi_wait;
  logic                  core_pcpi_ready;
  logic                  cp_pcpi_valid;
  logic [31:0]           cp_pcpi_insn;
  logic [31:0]           cp_pcpi_rs1;
  logic [31:0]           cp_pcpi_rs2;
  logic [NUM_CP-1:0]     cp_pcpi_wr;
  logic [32*NUM_CP-1:0]  cp_pcpi_rd;
  logic [NUM_CP-1:0]     cp_pcpi_wait;
  logic [NUM_CP-1:0]     cp_pcpi_ready;

  modport slave (
    input  core_pcpi_valid, core_pcpi_insn, core_pcpi_rs1, core_pcpi_rs2,
    input  cp_pcpi_wr, cp_pcpi_rd, cp_pcpi_wait, cp_pcpi_ready,
    output core_pcpi_wr, core_pcpi_rd, core_pcpi_wait, core_pcpi_ready,
    output cp_pcpi_valid, cp_pcpi_insn, cp_pcpi_rs1, cp_pcpi_rs2
  );

  modport master (
    output core_pcpi_valid, core_pcpi_insn, core_pcpi_rs1, core_pcpi_rs2,
    output cp_pcpi_wr, cp_pcpi_rd, cp_pcpi_wait, cp_pcpi_ready,
    input  core_pcpi_wr, core_pcpi_rd, core_pcpi_wait, core_pcpi_ready,
    input  cp_pcpi_valid, cp_pcpi_insn, cp_pcpi_rs1, cp_pcpi_rs2
  );
endinterface

// File: rtl/picorv32_pcpi_hub.sv
// Registered PCPI fan-out/fan-in: +1 cycle to the coprocessors, +1 cycle back; lowest ready index wins.
// Owns the "nobody claimed it" timeout; the core holds valid until it sees ready, or until it aborts.
module picorv32_pcpi_hub #(
  parameter int NUM_CP         = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                resetn,
  picorv32_pcpi_hub_if.slave  pcpi,
  output logic                busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, BUSY, RESP, DRAIN, TMO} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   insn_q, rs1_q, rs2_q, rd_q;
  logic          cp_valid_q, wait_q, ready_q, wr_q;

  logic          sel_hit;
  logic          sel_wr;
  logic [31:0]   sel_rd;
  logic          any_wait;

  // Walk from the top down so the lowest ready index overwrites the rest.
  always_comb begin
    sel_hit = 1'b0;
    sel_wr  = 1'b0;
    sel_rd  = '0;
    for (int i = NUM_CP - 1; i >= 0; i--) begin
      if (pcpi.cp_pcpi_ready[i]) begin
        sel_hit = 1'b1;
        sel_wr  = pcpi.cp_pcpi_wr[i];
        sel_rd  = pcpi.cp_pcpi_rd[32*i +: 32];
      end
    end
  end

  assign any_wait = |pcpi.cp_pcpi_wait;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      insn_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      wr_q       <= 1'b0;
      cp_valid_q <= 1'b0;
      wait_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pcpi.core_pcpi_valid) begin
            insn_q     <= pcpi.core_pcpi_insn;
            rs1_q      <= pcpi.core_pcpi_rs1;
            rs2_q      <= pcpi.core_pcpi_rs2;
            cnt        <= '0;
            cp_valid_q <= 1'b1;
            wait_q     <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Abort beats ready, ready beats the final timeout step.
          if (!pcpi.core_pcpi_valid) begin
            cp_valid_q <= 1'b0;
            wait_q     <= 1'b0;
            state      <= IDLE;
          end else if (sel_hit) begin
            wr_q       <= sel_wr;
            rd_q       <= sel_rd;
            ready_q    <= 1'b1;
            cp_valid_q <= 1'b0;
            wait_q     <= 1'b0;
            state      <= RESP;
          end else if (!any_wait) begin
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              cp_valid_q <= 1'b0;
              wait_q     <= 1'b0;
              state      <= TMO;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          wr_q    <= 1'b0;
          rd_q    <= '0;
          state   <= DRAIN;
        end
        DRAIN, TMO: begin
          // Wait for the core to retire the request so it is never re-issued.
          if (!pcpi.core_pcpi_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pcpi.cp_pcpi_valid   = cp_valid_q;
  assign pcpi.cp_pcpi_insn    = insn_q;
  assign pcpi.cp_pcpi_rs1     = rs1_q;
  assign pcpi.cp_pcpi_rs2     = rs2_q;
  assign pcpi.core_pcpi_wait  = wait_q;
  assign pcpi.core_pcpi_ready = ready_q;
  assign pcpi.core_pcpi_wr    = wr_q;
  assign pcpi.core_pcpi_rd    = rd_q;
  assign busy                 = (state != IDLE);
endmodule

// File: tb/tb_picorv32_pcpi_hub.sv
// Directed bench for picorv32_pcpi_hub: expected responses queued when the cp answers, checked on core_pcpi_ready.
module tb_picorv32_pcpi_hub;
  localparam int NUM_CP = 2;
  localparam int TMO    = 16;
  localparam logic [31:0] MUL_INSN = 32'h02B50533;
  localparam logic [31:0] DIV_INSN = 32'h02B54533;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
  } resp_t;

  logic  clk;
  logic  resetn;
  logic  busy;
  int    checks;
  int    errors;
  resp_t sb[$];

  picorv32_pcpi_hub_if #(.NUM_CP(NUM_CP)) pif ();

  picorv32_pcpi_hub #(.NUM_CP(NUM_CP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pcpi   (pif),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_cp();
    pif.cp_pcpi_ready = '0;
    pif.cp_pcpi_wait  = '0;
    pif.cp_pcpi_wr    = '0;
    pif.cp_pcpi_rd    = '0;
  endtask

  task automatic issue(string tag, logic [31:0] insn, logic [31:0] rs1, logic [31:0] rs2);
    pif.core_pcpi_valid = 1'b1;
    pif.core_pcpi_insn  = insn;
    pif.core_pcpi_rs1   = rs1;
    pif.core_pcpi_rs2   = rs2;
    tick();
    chk1 ({tag, "_cpvalid"}, pif.cp_pcpi_valid, 1'b1);
    chk32({tag, "_insn"}, pif.cp_pcpi_insn, insn);
    chk32({tag, "_rs1"}, pif.cp_pcpi_rs1, rs1);
    chk32({tag, "_rs2"}, pif.cp_pcpi_rs2, rs2);
    chk1 ({tag, "_wait"}, pif.core_pcpi_wait, 1'b1);
  endtask

  // Drive one cycle of cp ready; the response must appear at the next sample point.
  task automatic cp_respond(string tag, logic [NUM_CP-1:0] rdy, logic [NUM_CP-1:0] wr,
                            logic [32*NUM_CP-1:0] rd, logic exp_wr, logic [31:0] exp_rd);
    resp_t e;
    pif.cp_pcpi_ready = rdy;
    pif.cp_pcpi_wr    = wr;
    pif.cp_pcpi_rd    = rd;
    e.wr = exp_wr;
    e.rd = exp_rd;
    sb.push_back(e);
    tick();
    clear_cp();
    if (pif.core_pcpi_ready === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk1 ({tag, "_wr"}, pif.core_pcpi_wr, e.wr);
      chk32({tag, "_rd"}, pif.core_pcpi_rd, e.rd);
    end else begin
      chk1({tag, "_ready"}, pif.core_pcpi_ready, 1'b1);
    end
    chk1({tag, "_cpvalid_drop"}, pif.cp_pcpi_valid, 1'b0);
  endtask

  // Core sees ready, then drops valid one cycle later like picorv32 does.
  task automatic finish_core(string tag);
    tick();
    chk1 ({tag, "_ready_pulse"}, pif.core_pcpi_ready, 1'b0);
    chk32({tag, "_rd_clr"}, pif.core_pcpi_rd, 32'h0);
    chk1 ({tag, "_wr_clr"}, pif.core_pcpi_wr, 1'b0);
    chk1 ({tag, "_drain_busy"}, busy, 1'b1);
    pif.core_pcpi_valid = 1'b0;
    tick();
    chk1({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int bad;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    pif.core_pcpi_valid = 1'b0;
    pif.core_pcpi_insn  = '0;
    pif.core_pcpi_rs1   = '0;
    pif.core_pcpi_rs2   = '0;
    clear_cp();
    tick();
    tick();
    chk1 ("rst_busy", busy, 1'b0);
    chk1 ("rst_cpvalid", pif.cp_pcpi_valid, 1'b0);
    chk1 ("rst_wait", pif.core_pcpi_wait, 1'b0);
    chk1 ("rst_ready", pif.core_pcpi_ready, 1'b0);
    chk32("rst_rd", pif.core_pcpi_rd, 32'h0);
    chk32("rst_insn", pif.cp_pcpi_insn, 32'h0);
    resetn = 1'b1;
    tick();

    // Stray ready while idle is ignored.
    pif.cp_pcpi_ready = 2'b01;
    pif.cp_pcpi_rd    = 64'h0000_0000_0000_0099;
    tick();
    clear_cp();
    chk1("idle_ready_ignored", pif.core_pcpi_ready, 1'b0);
    chk1("idle_stays", busy, 1'b0);

    // MUL 7*6 via cp0, two cycles of cp latency.
    issue("mul", MUL_INSN, 32'd7, 32'd6);
    chk1("mul_busy", busy, 1'b1);
    tick();
    cp_respond("mul", 2'b01, 2'b01, 64'h0000_0000_0000_002A, 1'b1, 32'd42);
    finish_core("mul");

    // cp1 answers with wr=0.
    issue("div", DIV_INSN, 32'd100, 32'd3);
    cp_respond("cp1", 2'b10, 2'b00, 64'hDEAD_BEEF_0000_0000, 1'b0, 32'hDEADBEEF);
    finish_core("cp1");

    // Nobody answers: wait held for exactly TMO cycles.
    issue("tmo", 32'h0000_000B, 32'd1, 32'd2);
    n = 0;
    while (pif.core_pcpi_wait === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk32("tmo_wait_cycles", n, TMO);
    chk1 ("tmo_cpvalid", pif.cp_pcpi_valid, 1'b0);
    bad = 0;
    repeat (5) begin
      if (pif.core_pcpi_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    chk32("tmo_holds", bad, 0);
    pif.core_pcpi_valid = 1'b0;
    tick();
    chk1("tmo_idle", busy, 1'b0);
    chk1("tmo_no_ready", pif.core_pcpi_ready, 1'b0);

    // Ready on the cycle of the final timeout step wins.
    issue("edge", MUL_INSN, 32'd3, 32'd3);
    repeat (TMO - 1) tick();
    chk1("edge_still_wait", pif.core_pcpi_wait, 1'b1);
    cp_respond("edge", 2'b01, 2'b01, 64'h0000_0000_0000_0009, 1'b1, 32'd9);
    finish_core("edge");

    // Long wait from cp1 suppresses the timeout.
    issue("long", DIV_INSN, 32'd5, 32'd5);
    pif.cp_pcpi_wait = 2'b10;
    bad = 0;
    repeat (40) begin
      tick();
      if (pif.core_pcpi_wait !== 1'b1) bad++;
    end
    chk32("long_wait_held", bad, 0);
    cp_respond("long", 2'b10, 2'b10, 64'h1234_5678_0000_0000, 1'b1, 32'h12345678);
    finish_core("long");

    // Simultaneous ready: cp0 wins.
    issue("prio", MUL_INSN, 32'd1, 32'd1);
    cp_respond("prio", 2'b11, 2'b11, 64'h5555_FFFF_AAAA_0000, 1'b1, 32'hAAAA0000);
    finish_core("prio");

    // Abort in the same cycle as a ready: abort wins, no response.
    issue("abort", MUL_INSN, 32'd2, 32'd2);
    pif.core_pcpi_valid = 1'b0;
    pif.cp_pcpi_ready   = 2'b01;
    pif.cp_pcpi_rd      = 64'h0000_0000_0000_0004;
    tick();
    clear_cp();
    chk1("abort_no_ready", pif.core_pcpi_ready, 1'b0);
    chk1("abort_idle", busy, 1'b0);
    chk1("abort_cpvalid", pif.cp_pcpi_valid, 1'b0);
    tick();
    chk1("abort_no_late_ready", pif.core_pcpi_ready, 1'b0);

    // Asynchronous reset mid-BUSY.
    issue("arst", MUL_INSN, 32'd9, 32'd9);
    #2;
    resetn = 1'b0;
    #1;
    chk1 ("arst_busy", busy, 1'b0);
    chk1 ("arst_cpvalid", pif.cp_pcpi_valid, 1'b0);
    chk1 ("arst_wait", pif.core_pcpi_wait, 1'b0);
    chk32("arst_insn", pif.cp_pcpi_insn, 32'h0);
    pif.core_pcpi_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    issue("post", MUL_INSN, 32'hFFFFFFFF, 32'd2);
    cp_respond("post", 2'b01, 2'b01, 64'h0000_0000_FFFF_FFFE, 1'b1, 32'hFFFFFFFE);
    finish_core("post");

    chk32("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
